// File: rtl/pad_cfg_ctrl_pkg.sv
// Shared types and constants for the pad ring configuration controller:
// FSM states, per-pad field layout and the safe power-up pad settings.
package pad_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  localparam int BIDIR_CFG_W = 6;
  localparam int INPUT_CFG_W = 2;

  localparam int F_OE = 0;
  localparam int F_CS = 1;
  localparam int F_SL = 2;
  localparam int F_IE = 3;
  localparam int F_PU = 4;
  localparam int F_PD = 5;

  localparam int F_IN_PU = 0;
  localparam int F_IN_PD = 1;

  // Power-up state keeps every bidir pad an input, pulled down, so nothing drives the board.
  localparam logic [BIDIR_CFG_W-1:0] BIDIR_SAFE = 6'b10_1000;
  localparam logic [INPUT_CFG_W-1:0] INPUT_SAFE = 2'b00;

endpackage

// File: rtl/pad_cfg_ctrl_if.sv
// Serial configuration port of the pad controller: shift/commit requests
// from the configuration master and status returned by the controller.
interface pad_cfg_ctrl_if;

  logic cfg_shift;
  logic cfg_sin;
  logic cfg_commit;
  logic cfg_sout;
  logic cfg_busy;
  logic cfg_valid;
  logic cfg_err;

  modport master (
    output cfg_shift, cfg_sin, cfg_commit,
    input  cfg_sout, cfg_busy, cfg_valid, cfg_err
  );

  modport slave (
    input  cfg_shift, cfg_sin, cfg_commit,
    output cfg_sout, cfg_busy, cfg_valid, cfg_err
  );

endinterface

// File: rtl/pad_cfg_ctrl_sync_bits.sv
// Multi-stage flop synchroniser bringing asynchronous pad inputs into the
// core clock domain; output lags the input by exactly STAGES clock edges.
module sync_bits #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [STAGES-1:0][WIDTH-1:0] r_stage;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage <= '0;
    end else begin
      r_stage <= {r_stage[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/pad_cfg_ctrl.sv
// Pad ring configuration: serial shadow chain with length-checked commit into
// active pad controls, plus synchronisation of pad Y inputs into the core domain.
module pad_cfg_ctrl
  import pad_cfg_pkg::*;
#(
  parameter int NUM_BIDIR_PADS = 16,
  parameter int NUM_INPUT_PADS = 12,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  pad_cfg_ctrl_if.slave             cfg,
  input  logic [NUM_BIDIR_PADS-1:0] i_core_out,
  input  logic [NUM_BIDIR_PADS-1:0] i_core_oe,
  output logic [NUM_BIDIR_PADS-1:0] o_core_in,
  output logic [NUM_INPUT_PADS-1:0] o_input_in,
  input  logic [NUM_BIDIR_PADS-1:0] i_bidir_y,
  input  logic [NUM_INPUT_PADS-1:0] i_input_y,
  output logic [NUM_BIDIR_PADS-1:0] o_bidir_a,
  output logic [NUM_BIDIR_PADS-1:0] o_bidir_oe,
  output logic [NUM_BIDIR_PADS-1:0] o_bidir_cs,
  output logic [NUM_BIDIR_PADS-1:0] o_bidir_sl,
  output logic [NUM_BIDIR_PADS-1:0] o_bidir_ie,
  output logic [NUM_BIDIR_PADS-1:0] o_bidir_pu,
  output logic [NUM_BIDIR_PADS-1:0] o_bidir_pd,
  output logic [NUM_INPUT_PADS-1:0] o_input_pu,
  output logic [NUM_INPUT_PADS-1:0] o_input_pd
);

  localparam int NB = NUM_BIDIR_PADS;
  localparam int NI = NUM_INPUT_PADS;
  localparam int BW = BIDIR_CFG_W * NB;
  localparam int IW = INPUT_CFG_W * NI;
  localparam int L  = BW + IW;
  localparam int CW = $clog2(L + 2);

  localparam logic [CW-1:0] COUNT_FULL = CW'(L);
  localparam logic [CW-1:0] COUNT_SAT  = CW'(L + 1);

  state_e        r_state;
  state_e        w_next_state;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_next;
  logic [L-1:0]  r_chain;
  logic          r_sout;
  logic          r_valid;
  logic          r_err;
  logic [BW-1:0] r_act_bidir;
  logic [IW-1:0] r_act_input;
  logic          w_do_shift;
  logic          w_reject;
  logic          w_do_commit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // A commit is only honoured when exactly L bits were shifted since the last exit to IDLE.
  always_comb begin
    w_next_state = r_state;
    w_count_next = r_count;
    w_do_shift   = 1'b0;
    w_reject     = 1'b0;
    w_do_commit  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cfg.cfg_shift) begin
          w_do_shift   = 1'b1;
          w_reject     = cfg.cfg_commit;
          w_count_next = CW'(1);
          w_next_state = ST_SHIFT;
        end else if (cfg.cfg_commit) begin
          w_reject = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (cfg.cfg_shift) begin
          w_do_shift   = 1'b1;
          w_reject     = cfg.cfg_commit;
          w_count_next = (r_count == COUNT_SAT) ? r_count : r_count + CW'(1);
        end else if (cfg.cfg_commit) begin
          if (r_count == COUNT_FULL) begin
            w_next_state = ST_COMMIT;
          end else begin
            w_reject     = 1'b1;
            w_count_next = '0;
            w_next_state = ST_IDLE;
          end
        end
      end
      ST_COMMIT: begin
        w_do_commit  = 1'b1;
        w_count_next = '0;
        w_next_state = ST_IDLE;
      end
      default: begin
        w_count_next = '0;
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count     <= '0;
      r_chain     <= '0;
      r_sout      <= 1'b0;
      r_valid     <= 1'b0;
      r_err       <= 1'b0;
      r_act_bidir <= {NB{BIDIR_SAFE}};
      r_act_input <= {NI{INPUT_SAFE}};
    end else begin
      r_count <= w_count_next;
      if (w_do_shift) begin
        r_chain <= {cfg.cfg_sin, r_chain[L-1:1]};
        r_sout  <= r_chain[0];
      end
      if (w_reject) begin
        r_err <= 1'b1;
      end
      if (w_do_commit) begin
        r_err       <= 1'b0;
        r_valid     <= 1'b1;
        r_act_bidir <= r_chain[BW-1:0];
        r_act_input <= r_chain[L-1:BW];
      end
    end
  end

  assign cfg.cfg_sout  = r_sout;
  assign cfg.cfg_busy  = (r_state != ST_IDLE);
  assign cfg.cfg_valid = r_valid;
  assign cfg.cfg_err   = r_err;

  // The core can only drive a pad the active config has enabled for output.
  always_comb begin
    o_bidir_oe = '0;
    o_bidir_cs = '0;
    o_bidir_sl = '0;
    o_bidir_ie = '0;
    o_bidir_pu = '0;
    o_bidir_pd = '0;
    o_input_pu = '0;
    o_input_pd = '0;
    for (int i = 0; i < NB; i++) begin
      o_bidir_oe[i] = r_act_bidir[i*BIDIR_CFG_W + F_OE] & i_core_oe[i];
      o_bidir_cs[i] = r_act_bidir[i*BIDIR_CFG_W + F_CS];
      o_bidir_sl[i] = r_act_bidir[i*BIDIR_CFG_W + F_SL];
      o_bidir_ie[i] = r_act_bidir[i*BIDIR_CFG_W + F_IE];
      o_bidir_pu[i] = r_act_bidir[i*BIDIR_CFG_W + F_PU];
      o_bidir_pd[i] = r_act_bidir[i*BIDIR_CFG_W + F_PD];
    end
    for (int j = 0; j < NI; j++) begin
      o_input_pu[j] = r_act_input[j*INPUT_CFG_W + F_IN_PU];
      o_input_pd[j] = r_act_input[j*INPUT_CFG_W + F_IN_PD];
    end
  end

  assign o_bidir_a = i_core_out;

  sync_bits #(
    .WIDTH  (NB),
    .STAGES (SYNC_STAGES)
  ) u_sync_bidir (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (i_bidir_y),
    .o_q   (o_core_in)
  );

  sync_bits #(
    .WIDTH  (NI),
    .STAGES (SYNC_STAGES)
  ) u_sync_input (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (i_input_y),
    .o_q   (o_input_in)
  );

endmodule
